// File: rtl/smpc_periph_stream_if.sv
// Output-side bus of the SMPC peripheral stream generator.
//   ACT   : INTBACK peripheral phase active (low aborts / rearms)
//   CONT  : continue request after the output buffer filled
//   DATA  : output byte
//   WE    : one-CLK write strobe for DATA at POS
//   POS   : buffer index of DATA
//   PAUSE : buffer full, more bytes pending
//   DONE  : stream complete
// Handshake: a byte is transferred on every CLK where WE=1; the consumer must
// accept it unconditionally. PAUSE=1 holds the producer until CONT=1 is seen
// on a CE cycle. DONE=1 holds until ACT drops.
interface smpc_periph_stream_if #(
  parameter int PW = 5
);
  logic          ACT;
  logic          CONT;
  logic [7:0]    DATA;
  logic          WE;
  logic [PW-1:0] POS;
  logic          PAUSE;
  logic          DONE;

  modport master (input ACT, CONT, output DATA, WE, POS, PAUSE, DONE);
  modport slave  (output ACT, CONT, input DATA, WE, POS, PAUSE, DONE);
endinterface

// File: rtl/smpc_periph_stream.sv
// SMPC INTBACK peripheral-data byte stream generator.
// Walks NUM_PORTS ports (direct or multitap), emitting one byte per CE cycle
// into the SMPC output buffer, pausing when the buffer fills.
// Ports:
//   CLK, RST_N   : clock, asynchronous active-low reset
//   CE           : SMPC clock enable
//   PORT_TAP     : per port, 1 = multitap, 0 = direct
//   SLOT_TYPE    : 3-bit pad type per slot
//   SLOT_BTN     : 16-bit active-low buttons per slot
//   SLOT_AXIS    : 48-bit axes per slot, LSB first X1 Y1 Z1 X2 Y2 Z2
//   bus          : ACT/CONT in, DATA/WE/POS/PAUSE/DONE out
//   DBG_STATE_O  : current sequencer state
module smpc_periph_stream #(
  parameter int NUM_PORTS = 2,
  parameter int TAP_SLOTS = 6,
  parameter int BUF_BYTES = 32
) (
  input  logic                            CLK,
  input  logic                            RST_N,
  input  logic                            CE,
  input  logic [NUM_PORTS-1:0]            PORT_TAP,
  input  logic [NUM_PORTS*TAP_SLOTS*3-1:0]  SLOT_TYPE,
  input  logic [NUM_PORTS*TAP_SLOTS*16-1:0] SLOT_BTN,
  input  logic [NUM_PORTS*TAP_SLOTS*48-1:0] SLOT_AXIS,
  smpc_periph_stream_if.master            bus,
  output logic [2:0]                      DBG_STATE_O
);
  localparam int PW  = (BUF_BYTES > 1) ? $clog2(BUF_BYTES) : 1;
  localparam int PTW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [PW-1:0]  POS_LAST  = PW'(BUF_BYTES - 1);
  localparam logic [PTW-1:0] PORT_LAST = PTW'(NUM_PORTS - 1);
  localparam logic [3:0]     SLOT_LAST = 4'(TAP_SLOTS - 1);

  localparam logic [2:0] S_START  = 3'd0;
  localparam logic [2:0] S_PSTAT  = 3'd1;
  localparam logic [2:0] S_ID     = 3'd2;
  localparam logic [2:0] S_BODY   = 3'd3;
  localparam logic [2:0] S_NEXT   = 3'd4;
  localparam logic [2:0] S_PAUSED = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  function automatic logic is_off(input logic [2:0] t);
    return (t == 3'd1) || (t == 3'd7);
  endfunction

  function automatic logic [7:0] id_byte(input logic [2:0] t);
    case (t)
      3'd2:       return 8'h13;
      3'd3:       return 8'h15;
      3'd4:       return 8'h16;
      3'd5:       return 8'h19;
      3'd1, 3'd7: return 8'hFF;
      default:    return 8'h02;
    endcase
  endfunction

  // Index of the last body byte for each active type.
  function automatic logic [3:0] last_idx(input logic [2:0] t);
    case (t)
      3'd2:    return 4'd2;
      3'd3:    return 4'd4;
      3'd4:    return 4'd5;
      3'd5:    return 4'd8;
      default: return 4'd1;
    endcase
  endfunction

  function automatic logic [7:0] xy(input logic [7:0] v);
    return {~v[7], v[6:0]};
  endfunction

  // Body byte k for a slot. Bytes 0..3 are shared by all types; the 3D pad
  // swaps Z order and dual mission inserts a zero pad byte before axis set 2.
  function automatic logic [7:0] body_byte(input logic [2:0] t, input logic [15:0] b,
                                           input logic [47:0] a, input logic [3:0] k);
    case (k)
      4'd0:    return b[15:8];
      4'd1:    return b[7:0];
      4'd2:    return xy(a[7:0]);
      4'd3:    return xy(a[15:8]);
      4'd4:    return (t == 3'd4) ? a[47:40] : a[23:16];
      4'd5:    return (t == 3'd4) ? a[23:16] : 8'h00;
      4'd6:    return xy(a[31:24]);
      4'd7:    return xy(a[39:32]);
      4'd8:    return a[47:40];
      default: return 8'h00;
    endcase
  endfunction

  logic [2:0]     state_q, ret_q;
  logic [PTW-1:0] port_q;
  logic [3:0]     slot_q, cnt_q;
  logic           tap_q;
  logic [PW-1:0]  pos_q, nxt_pos_q;
  logic [7:0]     data_q;
  logic           we_q, pause_q, done_q;
  logic [2:0]     snap_type_q [TAP_SLOTS];
  logic [15:0]    snap_btn_q  [TAP_SLOTS];
  logic [47:0]    snap_axis_q [TAP_SLOTS];

  // Effective cursor: NEXT and START resolve to the byte they lead into, so
  // every eligible CE cycle emits exactly one byte.
  logic [2:0]     e_state;
  logic [PTW-1:0] e_port;
  logic [3:0]     e_slot;
  always_comb begin
    e_state = state_q;
    e_port  = port_q;
    e_slot  = slot_q;
    if (state_q == S_START) begin
      e_state = S_PSTAT;
      e_port  = '0;
      e_slot  = '0;
    end else if (state_q == S_NEXT) begin
      if (tap_q && (slot_q != SLOT_LAST)) begin
        e_state = S_ID;
        e_slot  = slot_q + 4'd1;
      end else begin
        e_state = S_PSTAT;
        e_port  = port_q + PTW'(1);
        e_slot  = '0;
      end
    end
  end

  logic [2:0]  cur_type;
  logic [15:0] cur_btn;
  logic [47:0] cur_axis;
  always_comb begin
    cur_type = '0;
    cur_btn  = '0;
    cur_axis = '0;
    for (int s = 0; s < TAP_SLOTS; s++) begin
      if (e_slot == 4'(s)) begin
        cur_type = snap_type_q[s];
        cur_btn  = snap_btn_q[s];
        cur_axis = snap_axis_q[s];
      end
    end
  end

  logic       live_tap;
  logic [2:0] live_type0;
  assign live_tap   = PORT_TAP[e_port];
  assign live_type0 = SLOT_TYPE[int'(e_port)*TAP_SLOTS*3 +: 3];

  logic [7:0] byte_d;
  logic [2:0] state_d;
  logic [3:0] cnt_d;
  logic       slot_end, port_end;
  always_comb begin
    byte_d   = 8'h00;
    state_d  = e_state;
    cnt_d    = cnt_q + 4'd1;
    slot_end = 1'b0;
    port_end = 1'b0;
    case (e_state)
      S_PSTAT: begin
        if (live_tap) begin
          byte_d  = {4'h1, 4'(TAP_SLOTS)};
          state_d = S_ID;
        end else if (is_off(live_type0)) begin
          byte_d   = 8'hF0;
          port_end = 1'b1;
        end else begin
          byte_d  = 8'hF1;
          state_d = S_ID;
        end
      end
      S_ID: begin
        byte_d = id_byte(cur_type);
        if (is_off(cur_type)) begin
          slot_end = 1'b1;
        end else begin
          state_d = S_BODY;
          cnt_d   = 4'd0;
        end
      end
      S_BODY: begin
        byte_d = body_byte(cur_type, cur_btn, cur_axis, cnt_q);
        if (cnt_q == last_idx(cur_type)) slot_end = 1'b1;
      end
      default: ;
    endcase
    if (slot_end && !(tap_q && (e_slot != SLOT_LAST))) port_end = 1'b1;
    if (port_end && (e_port == PORT_LAST)) state_d = S_DONE;
    else if (slot_end || port_end)         state_d = S_NEXT;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= S_START;
      ret_q     <= S_START;
      port_q    <= '0;
      slot_q    <= '0;
      cnt_q     <= '0;
      tap_q     <= 1'b0;
      pos_q     <= '0;
      nxt_pos_q <= '0;
      data_q    <= '0;
      we_q      <= 1'b0;
      pause_q   <= 1'b0;
      done_q    <= 1'b0;
      for (int s = 0; s < TAP_SLOTS; s++) begin
        snap_type_q[s] <= '0;
        snap_btn_q[s]  <= '0;
        snap_axis_q[s] <= '0;
      end
    end else begin
      we_q <= 1'b0;
      if (CE) begin
        if (!bus.ACT) begin
          state_q   <= S_START;
          port_q    <= '0;
          slot_q    <= '0;
          cnt_q     <= '0;
          pos_q     <= '0;
          nxt_pos_q <= '0;
          pause_q   <= 1'b0;
          done_q    <= 1'b0;
        end else begin
          case (state_q)
            S_PAUSED: begin
              if (bus.CONT) begin
                state_q   <= ret_q;
                pause_q   <= 1'b0;
                pos_q     <= '0;
                nxt_pos_q <= '0;
              end
            end
            S_DONE: ;
            default: begin
              data_q    <= byte_d;
              we_q      <= 1'b1;
              pos_q     <= nxt_pos_q;
              nxt_pos_q <= nxt_pos_q + PW'(1);
              port_q    <= e_port;
              slot_q    <= e_slot;
              cnt_q     <= cnt_d;
              if (e_state == S_PSTAT) begin
                tap_q <= live_tap;
                for (int s = 0; s < TAP_SLOTS; s++) begin
                  snap_type_q[s] <= SLOT_TYPE[(int'(e_port)*TAP_SLOTS + s)*3 +: 3];
                  snap_btn_q[s]  <= SLOT_BTN[(int'(e_port)*TAP_SLOTS + s)*16 +: 16];
                  snap_axis_q[s] <= SLOT_AXIS[(int'(e_port)*TAP_SLOTS + s)*48 +: 48];
                end
              end
              if (state_d == S_DONE) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else if (nxt_pos_q == POS_LAST) begin
                state_q <= S_PAUSED;
                ret_q   <= state_d;
                pause_q <= 1'b1;
              end else begin
                state_q <= state_d;
              end
            end
          endcase
        end
      end
    end
  end

  assign bus.DATA    = data_q;
  assign bus.WE      = we_q;
  assign bus.POS     = pos_q;
  assign bus.PAUSE   = pause_q;
  assign bus.DONE    = done_q;
  assign DBG_STATE_O = state_q;
endmodule

// File: tb/tb_smpc_periph_stream.sv
module tb_smpc_periph_stream;
  localparam int NP = 2;
  localparam int TS = 6;
  localparam int BB = 32;
  localparam int PW = 5;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic CE = 1'b0;
  int   ce_cnt = 0;
  always #5 CLK = ~CLK;
  // CE is high for one CLK out of every four.
  always @(negedge CLK) begin
    ce_cnt++;
    CE = (ce_cnt % 4 == 0);
  end

  logic [NP-1:0]       PORT_TAP;
  logic [NP*TS*3-1:0]  SLOT_TYPE;
  logic [NP*TS*16-1:0] SLOT_BTN;
  logic [NP*TS*48-1:0] SLOT_AXIS;
  logic [2:0]          dbg_state;

  smpc_periph_stream_if #(.PW(PW)) bus ();

  smpc_periph_stream #(.NUM_PORTS(NP), .TAP_SLOTS(TS), .BUF_BYTES(BB)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .CE          (CE),
    .PORT_TAP    (PORT_TAP),
    .SLOT_TYPE   (SLOT_TYPE),
    .SLOT_BTN    (SLOT_BTN),
    .SLOT_AXIS   (SLOT_AXIS),
    .bus         (bus),
    .DBG_STATE_O (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [PW+7:0] exp_q[$];
  logic [PW-1:0] exp_pos;
  logic [PW+7:0] mon_e;
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] b);
    exp_q.push_back({exp_pos, b});
    exp_pos = exp_pos + 1'b1;
  endtask

  // Monitor: every write strobe must match the head of the expected queue.
  always @(negedge CLK) begin
    if (bus.WE === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_we: got pos=%0d data=0x%02h required no write", bus.POS, bus.DATA);
      end else begin
        mon_e = exp_q.pop_front();
        check("stream_byte{pos,data}", 32'({bus.POS, bus.DATA}), 32'(mon_e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic ce_edges(input int n);
    repeat (n) begin
      @(posedge CLK);
      while (CE !== 1'b1) @(posedge CLK);
    end
  endtask

  task automatic set_slot(input int p, input int s, input logic [2:0] t,
                          input logic [15:0] b, input logic [47:0] a);
    int idx;
    idx = p * TS + s;
    SLOT_TYPE[idx*3 +: 3]  = t;
    SLOT_BTN[idx*16 +: 16] = b;
    SLOT_AXIS[idx*48 +: 48] = a;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge CLK);
      n++;
    end
    check({name, "_bytes_left"}, exp_q.size(), 0);
    exp_q.delete();
    @(negedge CLK);
  endtask

  task automatic wait_pause(input string name, input int budget);
    int n;
    n = 0;
    while (bus.PAUSE !== 1'b1 && n < budget) begin
      @(posedge CLK);
      n++;
    end
    @(negedge CLK);
    check(name, bus.PAUSE, 1);
  endtask

  task automatic drop_act();
    @(negedge CLK);
    bus.ACT = 1'b0;
    ce_edges(1);
    @(negedge CLK);
  endtask

  // Expected bytes for a stream where both ports are multitaps and every slot
  // is a dual mission pad; built from the bench's own input vectors.
  task automatic push_t5(input int n);
    logic [7:0]  s[$];
    logic [15:0] b;
    logic [47:0] a;
    for (int p = 0; p < NP; p++) begin
      s.push_back(8'h16);
      for (int k = 0; k < TS; k++) begin
        b = SLOT_BTN[(p*TS+k)*16 +: 16];
        a = SLOT_AXIS[(p*TS+k)*48 +: 48];
        s.push_back(8'h19);
        s.push_back(b[15:8]);
        s.push_back(b[7:0]);
        s.push_back(a[7:0] ^ 8'h80);
        s.push_back(a[15:8] ^ 8'h80);
        s.push_back(a[23:16]);
        s.push_back(8'h00);
        s.push_back(a[31:24] ^ 8'h80);
        s.push_back(a[39:32] ^ 8'h80);
        s.push_back(a[47:40]);
      end
    end
    for (int i = 0; i < n && i < s.size(); i++) push(s[i]);
  endtask

  task automatic setup_t5();
    int idx;
    PORT_TAP = 2'b11;
    for (int p = 0; p < NP; p++)
      for (int k = 0; k < TS; k++) begin
        idx = p * TS + k;
        set_slot(p, k, 3'd5, 16'h1000 + 16'(idx * 16'h0111),
                 {8'hE0 + 8'(idx), 8'h20 + 8'(idx*7), 8'h85 + 8'(idx),
                  8'h40 + 8'(idx), 8'hF0 - 8'(idx*5), 8'h10 + 8'(idx*3)});
      end
  endtask

  logic [7:0] v1[8] = '{8'hF1, 8'h02, 8'hFE, 8'hDC, 8'hF1, 8'h02, 8'h12, 8'h34};
  logic [7:0] v2[9] = '{8'hF1, 8'h16, 8'hA5, 8'h5A, 8'h00, 8'hFF, 8'h22, 8'h11, 8'hF0};
  logic [7:0] v3[10] = '{8'h16, 8'h02, 8'h0F, 8'h0F, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hF0};

  task automatic setup_direct();
    PORT_TAP = '0;
    SLOT_TYPE = '0;
    set_slot(0, 0, 3'd0, 16'hFEDC, 48'h0);
    set_slot(1, 0, 3'd0, 16'h1234, 48'h0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int sz;
    bus.ACT = 1'b0;
    bus.CONT = 1'b0;
    PORT_TAP = '0;
    SLOT_TYPE = '0;
    SLOT_BTN = '1;
    SLOT_AXIS = '0;
    exp_pos = '0;
    repeat (3) @(negedge CLK);
    check("reset_data", bus.DATA, 0);
    check("reset_we", bus.WE, 0);
    check("reset_pos", bus.POS, 0);
    check("reset_pause", bus.PAUSE, 0);
    check("reset_done", bus.DONE, 0);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);

    // 1: two direct digital pads
    setup_direct();
    exp_pos = '0;
    foreach (v1[i]) push(v1[i]);
    bus.ACT = 1'b1;
    wait_drain("t1", 400);
    check("t1_done", bus.DONE, 1);
    check("t1_pause", bus.PAUSE, 0);
    check("t1_last_pos", bus.POS, 7);
    ce_edges(10);
    @(negedge CLK);
    check("t1_done_hold", bus.DONE, 1);
    drop_act();
    check("t1_rearm_done", bus.DONE, 0);
    check("t1_rearm_pos", bus.POS, 0);

    // 2: 3D pad on port 0, port 1 off; CONT held high must be ignored
    SLOT_TYPE = '0;
    set_slot(0, 0, 3'd4, 16'hA55A, 48'h22_00_00_11_7F_80);
    set_slot(1, 0, 3'd1, 16'hFFFF, 48'h0);
    exp_pos = '0;
    foreach (v2[i]) push(v2[i]);
    bus.CONT = 1'b1;
    bus.ACT = 1'b1;
    wait_drain("t2", 400);
    check("t2_done", bus.DONE, 1);
    check("t2_last_pos", bus.POS, 8);
    bus.CONT = 1'b0;
    drop_act();

    // 3: multitap with one digital slot, direct port off
    PORT_TAP = 2'b01;
    set_slot(0, 0, 3'd0, 16'h0F0F, 48'h0);
    for (int k = 1; k < TS; k++) set_slot(0, k, (k % 2) ? 3'd1 : 3'd7, 16'hFFFF, 48'h0);
    set_slot(1, 0, 3'd1, 16'hFFFF, 48'h0);
    exp_pos = '0;
    foreach (v3[i]) push(v3[i]);
    bus.ACT = 1'b1;
    wait_drain("t3", 400);
    check("t3_done", bus.DONE, 1);
    check("t3_last_pos", bus.POS, 9);
    drop_act();

    // 4: two full multitaps of dual mission pads, three buffer pauses
    setup_t5();
    exp_pos = '0;
    push_t5(122);
    bus.ACT = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_pause("t4_pause", 600);
      check("t4_pause_pos", bus.POS, 31);
      check("t4_pending", exp_q.size(), 122 - 32 * (k + 1));
      sz = exp_q.size();
      ce_edges(20);
      @(negedge CLK);
      check("t4_stall", exp_q.size(), sz);
      check("t4_still_paused", bus.PAUSE, 1);
      bus.CONT = 1'b1;
      ce_edges(1);
      @(negedge CLK);
      bus.CONT = 1'b0;
      check("t4_cont_clears", bus.PAUSE, 0);
      check("t4_cont_no_write", bus.WE, 0);
      ce_edges(1);
      #1;
      check("t4_resume_we", bus.WE, 1);
      check("t4_resume_pos", bus.POS, 0);
    end
    wait_drain("t4", 800);
    check("t4_done", bus.DONE, 1);
    check("t4_done_pos", bus.POS, 25);
    check("t4_done_no_pause", bus.PAUSE, 0);
    drop_act();

    // 5: abort mid-record, relatch fresh inputs, then abort while paused
    exp_pos = '0;
    push_t5(5);
    bus.ACT = 1'b1;
    wait_drain("t5a", 400);
    bus.ACT = 1'b0;
    ce_edges(1);
    @(negedge CLK);
    check("t5_abort_pos", bus.POS, 0);
    check("t5_abort_done", bus.DONE, 0);
    set_slot(0, 0, 3'd5, 16'h5AA5, 48'h01_02_03_04_05_3C);
    exp_pos = '0;
    push_t5(5);
    bus.ACT = 1'b1;
    wait_drain("t5b", 400);
    drop_act();
    exp_pos = '0;
    push_t5(32);
    bus.ACT = 1'b1;
    wait_pause("t5_pause", 600);
    check("t5_pause_pos", bus.POS, 31);
    wait_drain("t5c", 10);
    drop_act();
    check("t5_abort_pause", bus.PAUSE, 0);
    check("t5_abort_pause_pos", bus.POS, 0);

    // 6: asynchronous reset mid-stream, then restart from port 0 status
    setup_direct();
    exp_pos = '0;
    foreach (v1[i]) push(v1[i]);
    bus.ACT = 1'b1;
    for (int n = 0; n < 400 && exp_q.size() > 5; n++) @(negedge CLK);
    check("t6_progress", exp_q.size(), 5);
    @(negedge CLK);
    #2 RST_N = 1'b0;
    #1;
    check("t6_rst_data", bus.DATA, 0);
    check("t6_rst_we", bus.WE, 0);
    check("t6_rst_pos", bus.POS, 0);
    check("t6_rst_pause", bus.PAUSE, 0);
    check("t6_rst_done", bus.DONE, 0);
    exp_q.delete();
    exp_pos = '0;
    foreach (v1[i]) push(v1[i]);
    @(negedge CLK);
    RST_N = 1'b1;
    wait_drain("t6", 400);
    check("t6_done", bus.DONE, 1);
    check("t6_last_pos", bus.POS, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/smpc_periph_stream.md
Name: smpc_periph_stream

Overview:
Generates the SMPC INTBACK peripheral-data byte stream for NUM_PORTS controller ports. Each port is either a direct connection or a multitap with TAP_SLOTS slots, and each slot carries its own pad type, buttons and six analog axes. Output is written byte-by-byte into the SMPC output-register buffer of BUF_BYTES entries. When the buffer fills, the block pauses and waits for a continue request, then resumes with the next byte. It sits between the HPS joystick inputs and the SMPC core.

Parameters:
NUM_PORTS, 2, number of controller ports (1..4)
TAP_SLOTS, 6, slots per multitap port (1..15)
BUF_BYTES, 32, output buffer depth; PW = $clog2(BUF_BYTES)

Ports:
CLK  in  1  system clock
RST_N  in  1  asynchronous, active-low reset
CE  in  1  SMPC clock enable; all state advances only on CLK edges with CE=1
ACT  in  1  INTBACK peripheral phase active; low aborts or rearms
CONT  in  1  continue request, sampled on CE cycles
PORT_TAP  in  NUM_PORTS  per port: 1 = multitap, 0 = direct (only slot 0 is used)
SLOT_TYPE  in  NUM_PORTS*TAP_SLOTS*3  pad type per slot
SLOT_BTN  in  NUM_PORTS*TAP_SLOTS*16  active-low buttons per slot
SLOT_AXIS  in  NUM_PORTS*TAP_SLOTS*48  per slot, LSB first: X1, Y1, Z1, X2, Y2, Z2 (8 bits each); X/Y signed centre-0, Z unsigned
DATA  out  8  output byte
WE  out  1  one-CLK write strobe for DATA at POS
POS  out  PW  buffer index of DATA
PAUSE  out  1  buffer full, more bytes pending
DONE  out  1  stream complete

Behaviour:
- Reset: DATA=0, WE=0, POS=0, PAUSE=0, DONE=0, internal state = START with port=0 and slot=0.
- Byte emission: on each CE cycle with ACT=1, PAUSE=0 and DONE=0, exactly one byte is emitted. DATA, POS and WE=1 are registered on that edge. WE returns to 0 on the next CLK edge regardless of CE.
- POS is 0 for the first byte and increments by 1 per byte.
- Snapshot: all slot inputs for a port are latched on the CE cycle that emits that port's status byte. The port's later bytes use only the latched values.
- Port status byte:
  - Direct port: F1 if slot0 type is active, F0 otherwise. F0 ends the port.
  - Multitap port: {4'h1, TAP_SLOTS[3:0]}, followed by the records for every slot in order.
- Slot record: ID byte, then the bytes for that type in the order listed below. For a direct port, the ID byte follows F1.
  - type 0 or 6 (digital / lightgun): ID 02; BTN[15:8], BTN[7:0]
  - type 2 (wheel): ID 13; BTN MSB, BTN LSB, X1
  - type 3 (mission): ID 15; BTN MSB, BTN LSB, X1, Y1, Z1
  - type 4 (3D pad): ID 16; BTN MSB, BTN LSB, X1, Y1, Z2, Z1
  - type 5 (dual mission): ID 19; BTN MSB, BTN LSB, X1, Y1, Z1, 00, X2, Y2, Z2
  - type 1 or 7 (off): direct port is handled by F0; in a multitap the slot emits the single byte FF.
- Axis conversion: X and Y are output as {~v[7], v[6:0]}. Z is passed through unchanged.
- Sequencer FSM states: START, PSTAT, ID, BODY (byte counter 0..8 indexed by type), NEXT, PAUSED, DONE.
  - NEXT advances the slot; after the last slot it advances the port.
  - After the last port, the state becomes DONE and the DONE output is 1.
  - In DONE, no further WE pulses occur.
- Buffer full: when a byte is emitted at POS = BUF_BYTES-1:
  - If more bytes remain, set PAUSE=1 and hold all state.
  - If it was the final byte, set DONE=1 and leave PAUSE=0.
- Continue: CONT=1 on a CE cycle while PAUSE=1 clears PAUSE and sets POS so that the next byte goes to index 0. That next byte is emitted on the following eligible CE cycle, not in the CONT cycle. CONT is ignored when PAUSE=0.
- Abort: ACT=0 on any CE cycle returns to START with POS=0, PAUSE=0, DONE=0 and WE=0. This applies even mid-record or while paused.
- Simultaneous ACT=0 and CONT=1: abort wins.
- CE=0: outputs hold, except that WE is always cleared one CLK after being set.

Test Plan:
- Direct pads, 2 ports, both type 0, BTN 0xFEDC and 0x1234, ACT=1 with CE every 4 CLK -> bytes F1 02 FE DC F1 02 12 34 at POS 0..7; then DONE=1 and no further WE.
- Port0 type 4 with X1=0x80, Y1=0x7F, Z1=0x11, Z2=0x22; port1 off -> bytes F1 16 BTNh BTNl 00 FF 22 11 F0; DONE after 9 bytes.
- Port0 multitap, TAP_SLOTS=6, slot0 digital, slots1-5 off; port1 direct off -> bytes 16 02 BH BL FF FF FF FF FF F0 (10 bytes).
- Two multitaps, all 12 slots type 5 (10 bytes per slot, 122 total) -> PAUSE rises after POS=31; bytes stall for 20 CE cycles. A CONT pulse makes the next byte appear at POS=0 one CE later. Expect 3 pauses and DONE at POS 25.
- Drop ACT for one CE mid dual-mission record, then raise it again -> next byte is the port0 status at POS 0 with freshly latched inputs. Repeat while PAUSE=1 -> PAUSE clears.
- Assert RST_N low mid-stream asynchronously -> all outputs are 0 immediately. After release, the stream restarts from the port0 status byte.
